// File: rtl/alu_uart_sequencer_if.sv
// Link between the ALU/UART sequencer and its surroundings: UART RX/TX
// handshakes, the combinational ALU inputs and its result.
interface alu_uart_sequencer_if #(
    parameter int unsigned N_BITS_DATA = 8,
    parameter int unsigned N_BITS_OP   = 6
);
    logic [N_BITS_DATA-1:0] i_rx_data;
    logic                   i_rx_done;
    logic                   i_tx_done;
    logic [N_BITS_DATA-1:0] i_alu_result;
    logic [N_BITS_DATA-1:0] o_dato_A;
    logic [N_BITS_DATA-1:0] o_dato_B;
    logic [N_BITS_OP-1:0]   o_operacion;
    logic [N_BITS_DATA-1:0] o_tx_data;
    logic                   o_tx_start;
    logic                   o_busy;
    logic                   o_timeout;
    logic                   o_overrun;

    // Sequencer side
    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_dato_A, o_dato_B, o_operacion, o_tx_data,
               o_tx_start, o_busy, o_timeout, o_overrun
    );

    // Environment side: UART RX/TX and ALU
    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_dato_A, o_dato_B, o_operacion, o_tx_data,
               o_tx_start, o_busy, o_timeout, o_overrun
    );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Collects operand A, operand B and op code from the UART receiver, lets the
// combinational ALU settle for one cycle, captures its result and hands it
// to the UART transmitter. A partial frame is dropped if the next byte is
// late; bytes arriving while a result is in flight are dropped and flagged.
module alu_uart_sequencer #(
    parameter int unsigned N_BITS_DATA    = 8,
    parameter int unsigned N_BITS_OP      = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    alu_uart_sequencer_if.slave  bus
);
    // A zero-width counter is illegal, so the disabled case keeps one bit
    localparam int unsigned     CW      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit              TMO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0]   TC_LAST = TMO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0]   CNT_MAX = '1;

    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic                   w_in_frame;
    logic                   w_busy_st;
    logic                   w_tmo_hit;

    logic [N_BITS_DATA-1:0] r_dato_A;
    logic [N_BITS_DATA-1:0] r_dato_B;
    logic [N_BITS_OP-1:0]   r_operacion;
    logic [N_BITS_DATA-1:0] r_tx_data;
    logic                   r_tx_start;
    logic                   r_timeout;
    logic                   r_overrun;

    assign w_in_frame = (r_state == WAIT_B) || (r_state == WAIT_OP);
    assign w_busy_st  = (r_state == EXEC) || (r_state == SEND) || (r_state == WAIT_TX);
    // A byte arriving on the terminal count wins over the timeout
    assign w_tmo_hit  = TMO_EN && w_in_frame && !bus.i_rx_done && (r_cnt == TC_LAST);

    // Next-state and timeout-counter update
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            WAIT_A:  if (bus.i_rx_done) w_next = WAIT_B;
            WAIT_B:  if (bus.i_rx_done) w_next = WAIT_OP;
                     else if (w_tmo_hit) w_next = WAIT_A;
            WAIT_OP: if (bus.i_rx_done) w_next = EXEC;
                     else if (w_tmo_hit) w_next = WAIT_A;
            EXEC:    w_next = SEND;
            SEND:    w_next = WAIT_TX;
            WAIT_TX: if (bus.i_tx_done) w_next = WAIT_A;
            default: w_next = WAIT_A;
        endcase
        if (w_next != r_state)
            w_cnt_next = '0;
        else if (TMO_EN && w_in_frame && (r_cnt != CNT_MAX))
            w_cnt_next = r_cnt + 1'b1;
    end

    // State register and timeout counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= WAIT_A;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Operand/op capture, result capture and one-cycle status pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dato_A    <= '0;
            r_dato_B    <= '0;
            r_operacion <= '0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_tx_start <= (r_state == SEND);
            r_timeout  <= w_tmo_hit;
            r_overrun  <= bus.i_rx_done && w_busy_st;
            if (bus.i_rx_done && (r_state == WAIT_A))  r_dato_A    <= bus.i_rx_data;
            if (bus.i_rx_done && (r_state == WAIT_B))  r_dato_B    <= bus.i_rx_data;
            if (bus.i_rx_done && (r_state == WAIT_OP)) r_operacion <= bus.i_rx_data[N_BITS_OP-1:0];
            if (r_state == EXEC)                       r_tx_data   <= bus.i_alu_result;
        end
    end

    assign bus.o_dato_A    = r_dato_A;
    assign bus.o_dato_B    = r_dato_B;
    assign bus.o_operacion = r_operacion;
    assign bus.o_tx_data   = r_tx_data;
    assign bus.o_tx_start  = r_tx_start;
    assign bus.o_busy      = w_busy_st;
    assign bus.o_timeout   = r_timeout;
    assign bus.o_overrun   = r_overrun;
endmodule
